parking_sensor_interface: RTL



---
 rtl/parking_pkg.sv | 26 ++
 rtl/parking_lane_tracker.sv | 186 ++++++++++++++++++
 rtl/parking_sensor_interface.sv | 60 ++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sensor interface.
// Build option: define WRONG_WAY_DETECT_EN to add the wrong_way output.
package parking_pkg;

    // Lane tracker states; 3-bit encoding, remaining codes are unused.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A     = 3'd1,
        AB    = 3'd2,
        B     = 3'd3,
        REV   = 3'd4,
        FAULT = 3'd5
    } lane_state_t;

    localparam int LANE_ENTRY = 0;
    localparam int LANE_EXIT  = 1;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 50000;

    // States in which a lane may dwell only for a bounded time.
    function automatic logic is_timed_state(input lane_state_t s);
        return (s == A) || (s == AB) || (s == B) || (s == REV);
    endfunction

endpackage

// File: rtl/parking_lane_tracker.sv
// One gate lane: 2-flop synchronisers and debouncers for both beams, a beam
// order FSM producing a one-cycle pass pulse, and a dwell timeout into FAULT.
// Build option: WRONG_WAY_DETECT_EN adds wrong_way_o.
//
// Handshake: none. passed_o / wrong_way_o are single-cycle strobes with no
// back-pressure; the consumer must sample them every clock.
module parking_lane_tracker
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sensor_a_i,
    input  logic sensor_b_i,
`ifdef WRONG_WAY_DETECT_EN
    output logic wrong_way_o,
`endif
    output logic passed_o,
    output logic busy_o,
    output logic fault_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    // Index 0 is beam a, index 1 is beam b.
    logic [1:0]      raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filt_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    lane_state_t     state_q;
    lane_state_t     state_d;
    logic [TO_W-1:0] dwell_q;
    logic [TO_W-1:0] dwell_d;
    logic [1:0]      ab;
    logic            pass_d;
    logic            pass_q;
    logic            busy_q;
    logic            fault_q;

    assign raw = {sensor_b_i, sensor_a_i};
    assign ab  = {filt_q[0], filt_q[1]};

    // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d[0] = '0;
        cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Synchroniser chain, filtered levels and debounce counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            filt_q   <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // Beam-order next state, dwell timeout and pulse decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                case (ab)
                    2'b10:   state_d = A;
                    2'b11:   state_d = AB;
                    2'b01:   state_d = REV;
                    default: state_d = IDLE;
                endcase
            end
            A: begin
                case (ab)
                    2'b11:   state_d = AB;
                    2'b01:   state_d = B;
                    2'b00:   state_d = IDLE;
                    default: state_d = A;
                endcase
            end
            AB: begin
                case (ab)
                    2'b01:   state_d = B;
                    2'b10:   state_d = A;
                    2'b00:   state_d = IDLE;
                    default: state_d = AB;
                endcase
            end
            B: begin
                case (ab)
                    2'b00:   state_d = IDLE;
                    2'b11:   state_d = AB;
                    2'b10:   state_d = A;
                    default: state_d = B;
                endcase
            end
            REV, FAULT: begin
                if (ab == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A lane stuck in one state for TIMEOUT_CYCLES is declared faulty.
        if (is_timed_state(state_q) && (dwell_q == TO_LAST)) begin
            state_d = FAULT;
        end

        dwell_d = dwell_q;
        if ((state_d != state_q) || (state_q == IDLE)) begin
            dwell_d = '0;
        end else if (dwell_q != TO_MAX) begin
            dwell_d = dwell_q + TO_W'(1);
        end

        pass_d = (state_q == B) && (state_d == IDLE);
    end

    // FSM state, dwell counter and registered lane outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dwell_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d != IDLE);
            fault_q <= (state_d == FAULT);
        end
    end

    assign passed_o = pass_q;
    assign busy_o   = busy_q;
    assign fault_o  = fault_q;

`ifdef WRONG_WAY_DETECT_EN
    logic ww_d;
    logic ww_q;

    // Wrong-way strobe on entering REV and again if REV times out.
    always_comb begin
        ww_d = ((state_q == IDLE) && (state_d == REV)) ||
               ((state_q == REV) && (state_d == FAULT));
    end

    // Registered wrong-way strobe, aligned with the state it reports.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ww_q <= 1'b0;
        end else begin
            ww_q <= ww_d;
        end
    end

    assign wrong_way_o = ww_q;
`endif

endmodule

// File: rtl/parking_sensor_interface.sv
// Parking gate sensor interface: two independent lane trackers turning raw
// dual-beam sensors into entry_passed / exit_passed pulses.
// Build option: WRONG_WAY_DETECT_EN adds the wrong_way[1:0] output.
module parking_sensor_interface
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       entry_sensor_a,
    input  logic       entry_sensor_b,
    input  logic       exit_sensor_a,
    input  logic       exit_sensor_b,
`ifdef WRONG_WAY_DETECT_EN
    output logic [1:0] wrong_way,
`endif
    output logic       entry_passed,
    output logic       exit_passed,
    output logic       entry_busy,
    output logic       exit_busy,
    output logic [1:0] sensor_fault
);

    // Entry lane: a is the outer beam, b the inner beam.
    parking_lane_tracker #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_entry (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .sensor_a_i  (entry_sensor_a),
        .sensor_b_i  (entry_sensor_b),
`ifdef WRONG_WAY_DETECT_EN
        .wrong_way_o (wrong_way[LANE_ENTRY]),
`endif
        .passed_o    (entry_passed),
        .busy_o      (entry_busy),
        .fault_o     (sensor_fault[LANE_ENTRY])
    );

    // Exit lane: a is the lot-side beam, b the street-side beam.
    parking_lane_tracker #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_exit (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .sensor_a_i  (exit_sensor_a),
        .sensor_b_i  (exit_sensor_b),
`ifdef WRONG_WAY_DETECT_EN
        .wrong_way_o (wrong_way[LANE_EXIT]),
`endif
        .passed_o    (exit_passed),
        .busy_o      (exit_busy),
        .fault_o     (sensor_fault[LANE_EXIT])
    );

endmodule
